// File: rtl/button_press_3s.sv
// -----------------------------------------------------------------------------
// button_press_3s
//
// Long-press detector. While the button is held, a prescaler divides clk_in
// down to a hold-timer tick (CLK_FREQ_HZ / TICK_HZ cycles per tick) and a
// 4-bit tick counter climbs toward HOLD_TICKS, where it saturates. The
// long-press indication is asserted whenever the counter sits at HOLD_TICKS.
// Any release, however short, restarts timing from zero.
//
// Build option:
//   BUTTON_PRESS_SYNC_EN - when defined, the raw button level passes through
//                          a two-flop synchronizer before use (adds exactly
//                          two cycles of latency). Undefined: used directly.
//
// Parameters:
//   CLK_FREQ_HZ - input clock frequency in Hz
//   TICK_HZ     - hold-timer tick rate in Hz
//   HOLD_TICKS  - ticks needed for a valid long press (1..15)
//
// Ports:
//   clk_in - system clock, all state updates on its rising edge
//   rst    - asynchronous active-high reset
//   button - raw push-button level, 1 = pressed
//   out    - 1 when the button has been held for at least HOLD_TICKS ticks
//   count  - current hold-tick count (mirror of the internal counter)
// -----------------------------------------------------------------------------
module button_press_3s #(
    parameter int CLK_FREQ_HZ = 50_000_000,
    parameter int TICK_HZ     = 4,
    parameter int HOLD_TICKS  = 12
) (
    input  logic       clk_in,
    input  logic       rst,
    input  logic       button,
    output logic       out,
    output logic [3:0] count
);

    // Clock cycles per hold-timer tick; must be at least 2.
    localparam int DIV   = CLK_FREQ_HZ / TICK_HZ;
    // Width that holds DIV-1 (for DIV >= 2, $clog2(DIV) bits suffice).
    localparam int DIV_W = (DIV > 1) ? $clog2(DIV) : 1;

    localparam logic [DIV_W-1:0] DIV_MAX  = DIV_W'(DIV - 1);
    localparam logic [DIV_W-1:0] DIV_ZERO = {DIV_W{1'b0}};
    localparam logic [DIV_W-1:0] DIV_ONE  = DIV_W'(1);
    localparam logic [3:0]       HOLD_MAX = 4'(HOLD_TICKS);

    logic             btn_s;
    logic [DIV_W-1:0] div;
    logic [3:0]       counter;

`ifdef BUTTON_PRESS_SYNC_EN
    logic sync1;
    logic sync2;

    // Two-flop synchronizer bringing the asynchronous button into clk_in.
    always_ff @(posedge clk_in or posedge rst) begin
        if (rst) begin
            sync1 <= 1'b0;
            sync2 <= 1'b0;
        end else begin
            sync1 <= button;
            sync2 <= sync1;
        end
    end

    assign btn_s = sync2;
`else
    assign btn_s = button;
`endif

    // Prescaler and saturating hold-tick counter; a released button clears
    // both so partial presses never accumulate.
    always_ff @(posedge clk_in or posedge rst) begin
        if (rst) begin
            div     <= DIV_ZERO;
            counter <= 4'd0;
        end else if (!btn_s) begin
            div     <= DIV_ZERO;
            counter <= 4'd0;
        end else if (div == DIV_MAX) begin
            div <= DIV_ZERO;
            if (counter < HOLD_MAX) begin
                counter <= counter + 4'd1;
            end else begin
                counter <= counter;
            end
        end else begin
            div     <= div + DIV_ONE;
            counter <= counter;
        end
    end

    // Long-press decode straight from the counter register.
    always_comb begin
        out = 1'b0;
        if (counter == HOLD_MAX) begin
            out = 1'b1;
        end else begin
            out = 1'b0;
        end
    end

    assign count = counter;

endmodule

// File: tb/tb_button_press_3s.sv
// -----------------------------------------------------------------------------
// tb_button_press_3s
//
// Directed bench for button_press_3s with CLK_FREQ_HZ=40, TICK_HZ=4
// (10 cycles per tick) and HOLD_TICKS=12. The expected count after every
// clock edge is derived from the length of the current unbroken run of
// pressed samples seen by the logic: count = min(run / 10, 12), out = 1 when
// that reaches 12. When BUTTON_PRESS_SYNC_EN is defined the bench delays its
// view of the button by two edges to match the synchronizer.
// -----------------------------------------------------------------------------
module tb_button_press_3s;

`ifdef BUTTON_PRESS_SYNC_EN
    localparam int LAT = 2;
`else
    localparam int LAT = 0;
`endif

    logic       clk_in = 1'b0;
    logic       rst    = 1'b0;
    logic       button = 1'b0;
    logic       out;
    logic [3:0] count;

    int errors = 0;
    int checks = 0;

    // Bench-side view of the button as the design sees it.
    logic d0  = 1'b0;
    logic d1  = 1'b0;
    logic bs  = 1'b0;
    int   run = 0;
    int   exp_cnt = 0;
    int   first_out_edge = -1;
    int   edge_no = 0;

    button_press_3s #(
        .CLK_FREQ_HZ(40),
        .TICK_HZ    (4),
        .HOLD_TICKS (12)
    ) dut (
        .clk_in(clk_in),
        .rst   (rst),
        .button(button),
        .out   (out),
        .count (count)
    );

    always #5 clk_in = ~clk_in;

    task automatic check(input string tag, input int exp_count, input logic exp_out);
        checks++;
        assert (count === 4'(exp_count))
        else begin
            errors++;
            $error("FAIL %s count: got %0d, expected %0d", tag, count, exp_count);
        end
        checks++;
        assert (out === exp_out)
        else begin
            errors++;
            $error("FAIL %s out: got %0b, expected %0b", tag, out, exp_out);
        end
    endtask

    // Advance one clock edge, update the expectation, sample 1 time unit later.
    task automatic tick(input string tag);
        @(posedge clk_in);
        edge_no++;
        if (rst) begin
            d0  = 1'b0;
            d1  = 1'b0;
            run = 0;
        end else begin
            bs  = (LAT == 0) ? button : d1;
            d1  = d0;
            d0  = button;
            run = bs ? run + 1 : 0;
        end
        exp_cnt = (run / 10 > 12) ? 12 : run / 10;
        #1;
        check(tag, exp_cnt, (exp_cnt == 12));
    endtask

    initial begin
        // Asynchronous reset before any clock edge.
        #2;
        rst = 1'b1;
        #1;
        check("reset_async_initial", 0, 1'b0);
        for (int i = 0; i < 3; i++) tick("reset_hold");
        rst = 1'b0;
        for (int i = 0; i < 5; i++) tick("idle_after_reset");

        // Press 1: hold for 150 cycles, note the edge where out first rises.
        button = 1'b1;
        edge_no = 0;
        first_out_edge = -1;
        for (int i = 0; i < 150; i++) begin
            tick("press1");
            if (out === 1'b1 && first_out_edge < 0) first_out_edge = edge_no;
        end
        checks++;
        assert (first_out_edge == 120 + LAT)
        else begin
            errors++;
            $error("FAIL press1_rise_edge: got %0d, expected %0d", first_out_edge, 120 + LAT);
        end
        check("press1_saturated", 12, 1'b1);

        // Release for a single cycle, then press again.
        button = 1'b0;
        tick("release1");
        button = 1'b1;
        for (int i = 0; i < LAT; i++) tick("release1_lat");
        check("release1_cleared", 0, 1'b0);
        edge_no = 0;
        first_out_edge = -1;
        for (int i = 0; i < 130; i++) begin
            tick("repress");
            if (out === 1'b1 && first_out_edge < 0) first_out_edge = edge_no;
        end
        checks++;
        assert (first_out_edge == 120)
        else begin
            errors++;
            $error("FAIL repress_rise_edge: got %0d, expected %0d", first_out_edge, 120);
        end

        // Clear, then two 119-cycle presses split by a one-cycle release.
        button = 1'b0;
        for (int i = 0; i < 4; i++) tick("gap");
        button = 1'b1;
        for (int i = 0; i < 119; i++) tick("short_a");
        for (int i = 0; i < LAT; i++) tick("short_a_lat");
        check("short_a_peak", 11, 1'b0);
        button = 1'b0;
        tick("short_gap");
        button = 1'b1;
        for (int i = 0; i < 119; i++) tick("short_b");
        button = 1'b0;
        for (int i = 0; i < LAT + 2; i++) tick("short_b_release");
        check("short_b_cleared", 0, 1'b0);

        // Mid-press asynchronous reset while count = 7.
        button = 1'b1;
        for (int i = 0; i < 70 + LAT; i++) tick("to_seven");
        check("at_seven", 7, 1'b0);
        #2;
        rst = 1'b1;
        #1;
        check("reset_async_midpress", 0, 1'b0);
        tick("reset_mid_hold");
        tick("reset_mid_hold");
        rst = 1'b0;
        for (int i = 0; i < 125 + LAT; i++) tick("resume_after_reset");
        check("resume_saturated", 12, 1'b1);

        button = 1'b0;
        for (int i = 0; i < LAT + 1; i++) tick("final_release");
        check("final_cleared", 0, 1'b0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    // Absolute time limit so the bench always ends.
    initial begin
        #200000;
        $display("FAIL timeout: simulation exceeded time limit");
        $fatal(1, "timeout");
    end

endmodule
